// File: rtl/hex_pkg.sv
// Shared definitions for the hex register readback path: FSM encoding,
// lane geometry and sweep-order helpers.
package hex_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned ADDR_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } hex_state_e;

  // Lane where a sweep begins for the given byte count and direction.
  function automatic logic [ADDR_W-1:0] lane_first(input int unsigned bytes,
                                                   input bit msb_first);
    return msb_first ? ADDR_W'(bytes - 1) : '0;
  endfunction

  // Lane whose transfer ends a sweep.
  function automatic logic [ADDR_W-1:0] lane_last(input int unsigned bytes,
                                                  input bit msb_first);
    return msb_first ? '0 : ADDR_W'(bytes - 1);
  endfunction

endpackage

// File: rtl/hex_byte_select.sv
// Combinational lane mux: picks one byte out of a packed register image.
// Addresses beyond the last lane read as zero.
module hex_byte_select
  import hex_pkg::*;
#(
  parameter int unsigned BYTES = 8
) (
  input  logic [BYTE_W*BYTES-1:0] lanes_i,
  input  logic [ADDR_W-1:0]       addr_i,
  output logic [BYTE_W-1:0]       byte_o
);

  always_comb begin
    byte_o = '0;
    for (int unsigned k = 0; k < BYTES; k++) begin
      if (addr_i == ADDR_W'(k)) byte_o = lanes_i[BYTE_W*k +: BYTE_W];
    end
  end

endmodule

// File: rtl/hex_reader.sv
// Streams a captured snapshot of the hex register image out one byte lane at
// a time over a valid/ready handshake, then pulses done.
module hex_reader
  import hex_pkg::*;
#(
  parameter int unsigned BYTES     = 8,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    abort,
  input  logic [BYTE_W*BYTES-1:0] hex,
  output logic                    readValid,
  input  logic                    readReady,
  output logic [BYTE_W-1:0]       readData,
  output logic [ADDR_W-1:0]       readAddress,
  output logic                    busy,
  output logic                    done
);

  localparam logic [ADDR_W-1:0] FIRST_LANE = lane_first(BYTES, MSB_FIRST);
  localparam logic [ADDR_W-1:0] LAST_LANE  = lane_last(BYTES, MSB_FIRST);
  localparam logic [ADDR_W-1:0] LANE_ONE   = ADDR_W'(1);

  hex_state_e                state_q, state_d;
  logic [ADDR_W-1:0]         index_q, index_d;
  logic [BYTE_W*BYTES-1:0]   snap_q,  snap_d;

  logic xfer;

  assign xfer = (state_q == SEND) && readReady;

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    snap_d  = snap_q;
    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          snap_d  = hex;
          index_d = FIRST_LANE;
          state_d = SEND;
        end
      end
      SEND: begin
        // Abort ends the sweep even if a byte transfers on the same edge.
        if (abort) begin
          state_d = IDLE;
        end else if (xfer) begin
          if (index_q == LAST_LANE) begin
            state_d = DONE;
          end else if (MSB_FIRST) begin
            index_d = index_q - LANE_ONE;
          end else begin
            index_d = index_q + LANE_ONE;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      index_q <= '0;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      snap_q  <= snap_d;
    end
  end

  assign readValid   = (state_q == SEND);
  assign done        = (state_q == DONE);
  assign busy        = (state_q != IDLE);
  assign readAddress = index_q;

  hex_byte_select #(
    .BYTES (BYTES)
  ) u_byte_select (
    .lanes_i (snap_q),
    .addr_i  (index_q),
    .byte_o  (readData)
  );

endmodule

// File: tb/tb_hex_reader.sv
// Directed bench for hex_reader: LSB-first and MSB-first instances checked
// against a byte/address scoreboard filled when each sweep is started.
module tb_hex_reader;

  localparam logic [63:0] H0 = 64'h8877665544332211;
  localparam logic [63:0] H1 = 64'h0123456789ABCDEF;
  localparam logic [63:0] HF = 64'hFFFFFFFFFFFFFFFF;

  typedef struct {
    logic [3:0] addr;
    logic [7:0] data;
  } exp_t;

  logic clock = 1'b0;
  logic rst_n = 1'b0;

  logic        start_a = 1'b0, abort_a = 1'b0, ready_a = 1'b0;
  logic [63:0] hex_a = '0;
  logic        valid_a, busy_a, done_a;
  logic [7:0]  data_a;
  logic [3:0]  addr_a;

  logic        start_b = 1'b0, abort_b = 1'b0, ready_b = 1'b0;
  logic [63:0] hex_b = '0;
  logic        valid_b, busy_b, done_b;
  logic [7:0]  data_b;
  logic [3:0]  addr_b;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  exp_t        sb[$];

  always #5 clock = ~clock;

  hex_reader #(.BYTES(8), .MSB_FIRST(1'b0)) dut_a (
    .clock(clock), .reset(rst_n), .start(start_a), .abort(abort_a), .hex(hex_a),
    .readValid(valid_a), .readReady(ready_a), .readData(data_a),
    .readAddress(addr_a), .busy(busy_a), .done(done_a)
  );

  hex_reader #(.BYTES(8), .MSB_FIRST(1'b1)) dut_b (
    .clock(clock), .reset(rst_n), .start(start_b), .abort(abort_b), .hex(hex_b),
    .readValid(valid_b), .readReady(ready_b), .readData(data_b),
    .readAddress(addr_b), .busy(busy_b), .done(done_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit use_b, input logic st, input logic ab,
                       input logic rdy, input logic [63:0] hv);
    if (use_b) begin
      start_b = st; abort_b = ab; ready_b = rdy; hex_b = hv;
    end else begin
      start_a = st; abort_a = ab; ready_a = rdy; hex_a = hv;
    end
  endtask

  task automatic sample(input bit use_b, output logic v, output logic [7:0] d,
                        output logic [3:0] a, output logic dn, output logic bz);
    if (use_b) begin
      v = valid_b; d = data_b; a = addr_b; dn = done_b; bz = busy_b;
    end else begin
      v = valid_a; d = data_a; a = addr_a; dn = done_a; bz = busy_a;
    end
  endtask

  task automatic push_exp(input logic [63:0] hv, input bit msb);
    int unsigned lane;
    exp_t e;
    for (int unsigned k = 0; k < 8; k++) begin
      lane   = msb ? 7 - k : k;
      e.addr = 4'(lane);
      e.data = hv[8*lane +: 8];
      sb.push_back(e);
    end
  endtask

  // Called at a negedge; starts a sweep and follows it to completion.
  task automatic sweep(input bit use_b, input logic [63:0] hv, input bit toggle,
                       input bit poke, input int abort_addr, input bit change_hex,
                       output int unsigned xfers, output int unsigned dones,
                       output int unsigned done_cyc, output int unsigned first_v);
    logic v, dn, bz;
    logic [7:0] d;
    logic [3:0] a;
    logic [63:0] cur_hex;
    bit rdy, ab, fin, ending;
    xfers = 0; dones = 0; done_cyc = 0; first_v = 0;
    fin = 0; ending = 0;
    cur_hex = hv;
    sb.delete();
    push_exp(hv, use_b);
    drive(use_b, 1'b1, 1'b0, 1'b1, cur_hex);
    for (int unsigned cyc = 1; cyc <= 40 && !fin; cyc++) begin
      @(negedge clock);
      sample(use_b, v, d, a, dn, bz);
      if (change_hex && cyc == 1) cur_hex = HF;
      ab  = 1'b0;
      rdy = toggle ? cyc[0] : 1'b1;
      if (ending) begin
        chk("end_busy", bz, 0);
        chk("end_valid", v, 0);
        chk("end_done", dn, 0);
        fin = 1;
      end else begin
        if (v) begin
          if (first_v == 0) first_v = cyc;
          if (sb.size() == 0) chk("extra_byte", 1, 0);
          else begin
            chk("data", d, sb[0].data);
            chk("addr", a, sb[0].addr);
          end
          if (abort_addr >= 0 && int'(a) == abort_addr) begin
            ab = 1'b1; rdy = 1'b1; ending = 1;
          end
          if (rdy && sb.size() != 0) begin
            void'(sb.pop_front());
            xfers++;
          end
        end
        if (dn) begin
          dones++;
          done_cyc = cyc;
          chk("done_valid_low", v, 0);
          ending = 1;
        end
      end
      drive(use_b, (poke && !fin) ? 1'b1 : 1'b0, ab, fin ? 1'b0 : rdy, cur_hex);
    end
    if (!fin) chk("sweep_timeout", 0, 1);
    drive(use_b, 1'b0, 1'b0, 1'b0, hv);
  endtask

  initial begin
    int unsigned xf, dn_n, dc, fv;
    bit hit;

    // Reset state
    repeat (2) @(negedge clock);
    chk("rst_valid", valid_a, 0);
    chk("rst_data", data_a, 0);
    chk("rst_addr", addr_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_b_data", data_b, 0);
    rst_n = 1'b1;
    @(negedge clock);

    // LSB-first with readReady high
    sweep(1'b0, H0, 1'b0, 1'b0, -1, 1'b0, xf, dn_n, dc, fv);
    chk("lsb_first_valid", fv, 1);
    chk("lsb_done_cycle", dc, 9);
    chk("lsb_xfers", xf, 8);
    chk("lsb_dones", dn_n, 1);
    chk("lsb_sb_empty", sb.size(), 0);

    // MSB-first
    sweep(1'b1, H0, 1'b0, 1'b0, -1, 1'b0, xf, dn_n, dc, fv);
    chk("msb_first_valid", fv, 1);
    chk("msb_done_cycle", dc, 9);
    chk("msb_xfers", xf, 8);
    chk("msb_dones", dn_n, 1);

    // readReady toggling: bytes hold through stalls
    sweep(1'b0, H0, 1'b1, 1'b0, -1, 1'b0, xf, dn_n, dc, fv);
    chk("tog_xfers", xf, 8);
    chk("tog_dones", dn_n, 1);
    chk("tog_done_cycle", dc, 16);

    // hex changed right after capture
    sweep(1'b0, H0, 1'b0, 1'b0, -1, 1'b1, xf, dn_n, dc, fv);
    chk("snap_xfers", xf, 8);
    chk("snap_dones", dn_n, 1);

    // abort at address 3, then fresh sweep
    sweep(1'b0, H0, 1'b0, 1'b0, 3, 1'b0, xf, dn_n, dc, fv);
    chk("abort_xfers", xf, 4);
    chk("abort_dones", dn_n, 0);
    sweep(1'b0, H1, 1'b0, 1'b0, -1, 1'b0, xf, dn_n, dc, fv);
    chk("post_abort_xfers", xf, 8);
    chk("post_abort_dones", dn_n, 1);
    chk("post_abort_first", fv, 1);

    // start held high through SEND and DONE
    sweep(1'b0, H0, 1'b0, 1'b1, -1, 1'b0, xf, dn_n, dc, fv);
    chk("poke_xfers", xf, 8);
    chk("poke_dones", dn_n, 1);
    chk("poke_done_cycle", dc, 9);

    // reset asserted at address 5
    drive(1'b0, 1'b1, 1'b0, 1'b1, H0);
    hit = 0;
    for (int unsigned i = 0; i < 20 && !hit; i++) begin
      @(negedge clock);
      drive(1'b0, 1'b0, 1'b0, 1'b1, H0);
      if (valid_a && addr_a == 4'd5) hit = 1;
    end
    chk("reach_addr5", hit, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", valid_a, 0);
    chk("arst_data", data_a, 0);
    chk("arst_addr", addr_a, 0);
    chk("arst_busy", busy_a, 0);
    chk("arst_done", done_a, 0);
    @(negedge clock);
    rst_n = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("post_rst_busy", busy_a, 0);
      chk("post_rst_done", done_a, 0);
    end

    // abort together with start in IDLE
    drive(1'b0, 1'b1, 1'b1, 1'b1, H0);
    @(negedge clock);
    chk("abort_start_busy", busy_a, 0);
    chk("abort_start_valid", valid_a, 0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, H0);
    @(negedge clock);
    chk("idle_busy", busy_a, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
